// File: rtl/segment_chase_decoder_if.sv
// segment_chase_decoder_if: segment lines in, decoded chase state out
//   master: drives seg_in, observes the decoded outputs
//   slave : the decoder (samples seg_in, drives the decoded outputs)
//   seg_in      raw segment lines a..g (bit i = segment i)
//   pos         decoded chase position 0..7
//   pos_valid   decoder locked
//   dir         1 = position increments, 0 = decrements
//   brightest   brightest segment of last window (7 = none)
//   step_pulse  one-cycle pulse per legal step
//   step_err    one-cycle pulse per illegal jump
//   step_period clk cycles between the last two legal steps
interface segment_chase_decoder_if #(
  parameter int PERIOD_WIDTH = 16
);
  logic [6:0] seg_in;
  logic [2:0] pos;
  logic pos_valid;
  logic dir;
  logic [2:0] brightest;
  logic step_pulse;
  logic step_err;
  logic [PERIOD_WIDTH-1:0] step_period;
  modport master (
    output seg_in,
    input pos, pos_valid, dir, brightest, step_pulse, step_err, step_period
  );
  modport slave (
    input seg_in,
    output pos, pos_valid, dir, brightest, step_pulse, step_err, step_period
  );
endinterface

// File: rtl/segment_chase_decoder.sv
// segment_chase_decoder: measures per-segment PWM duty over fixed windows, picks the
// brightest segment and tracks the figure-eight chase position, direction and step period.
//   clk      clock
//   reset_n  asynchronous reset, active-low
//   bus      segment_chase_decoder_if.slave (seg_in in, decoded chase state out)
// Optional feature: define CHASE_PERIOD_EN to build the step period counter;
// otherwise step_period is tied to 0.
module segment_chase_decoder #(
  parameter int WINDOW_WIDTH = 8,
  parameter int THRESHOLD = 8,
  parameter int COMMON_ANODE = 1,
  parameter int PERIOD_WIDTH = 16
) (
  input logic clk,
  input logic reset_n,
  segment_chase_decoder_if.slave bus
);
  // windows shorter than 32 cycles scale the count up instead of down
  localparam int SH_L = WINDOW_WIDTH >= 5 ? 0 : 5 - WINDOW_WIDTH;
  localparam int SH_R = WINDOW_WIDTH >= 5 ? WINDOW_WIDTH - 5 : 0;
  localparam logic [4:0] THR = 5'(THRESHOLD);
  localparam logic [2:0] SEG_OF_POS [8] = '{3'd0, 3'd1, 3'd6, 3'd4, 3'd3, 3'd2, 3'd6, 3'd5};
  // segment 6 is ambiguous (positions 2 and 6); its entry is never read
  localparam logic [2:0] POS_OF_SEG [8] = '{3'd0, 3'd1, 3'd5, 3'd4, 3'd3, 3'd7, 3'd2, 3'd0};
  typedef enum logic {UNLOCKED, LOCKED} lock_t;
  function automatic logic [4:0] quant(input logic [WINDOW_WIDTH:0] c);
    logic [WINDOW_WIDTH+5:0] w;
    w = ({5'b0, c} << SH_L) >> SH_R;
    return (|w[WINDOW_WIDTH+5:5]) ? 5'd31 : w[4:0];
  endfunction
  logic [6:0] sync1, sync2, lvl;
  logic [WINDOW_WIDTH-1:0] win_cnt;
  logic window_end, duty_new, bright_new;
  logic [WINDOW_WIDTH:0] cnt [7];
  logic [4:0] duty_q [7];
  logic [4:0] best_duty;
  logic [2:0] best, bright, prev_bright;
  lock_t state, state_n;
  logic [2:0] pos_q, pos_n, pos_inc, pos_dec;
  logic dir_q, dir_n, pulse_q, pulse_n, err_q, err_n;
  logic [PERIOD_WIDTH-1:0] period_q;
  assign lvl = (COMMON_ANODE != 0) ? ~sync2 : sync2;
  assign window_end = &win_cnt;
  assign pos_inc = pos_q + 3'd1;
  assign pos_dec = pos_q - 3'd1;
  // the sample taken on the window_end cycle seeds the next window's count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      win_cnt <= '0;
      duty_new <= 1'b0;
      bright_new <= 1'b0;
      bright <= 3'd7;
      prev_bright <= 3'd7;
      for (int i = 0; i < 7; i++) begin
        cnt[i] <= '0;
        duty_q[i] <= '0;
      end
    end else begin
      sync1 <= bus.seg_in;
      sync2 <= sync1;
      win_cnt <= win_cnt + 1'b1;
      duty_new <= window_end;
      bright_new <= duty_new;
      for (int i = 0; i < 7; i++) begin
        cnt[i] <= window_end ? {{WINDOW_WIDTH{1'b0}}, lvl[i]} : cnt[i] + {{WINDOW_WIDTH{1'b0}}, lvl[i]};
        if (window_end) duty_q[i] <= quant(cnt[i]);
      end
      if (duty_new) begin
        bright <= best;
        prev_bright <= bright;
      end
    end
  end
  // strict '>' keeps the lowest index on ties
  always_comb begin
    best = 3'd7;
    best_duty = '0;
    for (int i = 0; i < 7; i++)
      if (duty_q[i] >= THR && (best == 3'd7 || duty_q[i] > best_duty)) begin
        best = 3'(i);
        best_duty = duty_q[i];
      end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= UNLOCKED;
      pos_q <= 3'd0;
      dir_q <= 1'b0;
      pulse_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      pos_q <= pos_n;
      dir_q <= dir_n;
      pulse_q <= pulse_n;
      err_q <= err_n;
    end
  end
  // a step is legal when the neighbouring position maps to the new brightest segment
  always_comb begin
    state_n = state;
    pos_n = pos_q;
    dir_n = dir_q;
    pulse_n = 1'b0;
    err_n = 1'b0;
    if (bright_new && bright == 3'd7) state_n = UNLOCKED;
    else if (bright_new && bright != prev_bright) begin
      if (state == UNLOCKED) begin
        if (bright != 3'd6) begin
          state_n = LOCKED;
          pos_n = POS_OF_SEG[bright];
        end
      end else if (SEG_OF_POS[pos_inc] == bright) begin
        pos_n = pos_inc;
        dir_n = 1'b1;
        pulse_n = 1'b1;
      end else if (SEG_OF_POS[pos_dec] == bright) begin
        pos_n = pos_dec;
        dir_n = 1'b0;
        pulse_n = 1'b1;
      end else begin
        err_n = 1'b1;
        if (bright == 3'd6) state_n = UNLOCKED;
        else pos_n = POS_OF_SEG[bright];
      end
    end
  end
`ifdef CHASE_PERIOD_EN
  logic [PERIOD_WIDTH-1:0] period_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt <= '0;
      period_q <= '0;
    end else begin
      period_cnt <= pulse_n ? PERIOD_WIDTH'(1) : (&period_cnt ? period_cnt : period_cnt + 1'b1);
      if (pulse_n) period_q <= period_cnt;
    end
  end
`else
  assign period_q = {PERIOD_WIDTH{1'b0}};
`endif
  always_comb begin
    bus.pos = pos_q;
    bus.pos_valid = state == LOCKED;
    bus.dir = dir_q;
    bus.brightest = bright;
    bus.step_pulse = pulse_q;
    bus.step_err = err_q;
    bus.step_period = period_q;
  end
endmodule

// File: tb/tb_segment_chase_decoder.sv
// tb_segment_chase_decoder: table-driven check of the chase decoder with 16-cycle windows
module tb_segment_chase_decoder;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;
  segment_chase_decoder_if #(.PERIOD_WIDTH(16)) bus ();
  segment_chase_decoder #(
    .WINDOW_WIDTH(4),
    .THRESHOLD(8),
    .COMMON_ANODE(1),
    .PERIOD_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
`ifdef CHASE_PERIOD_EN
  localparam int P32 = 32;
`else
  localparam int P32 = 0;
`endif
  typedef struct {
    int mode;
    int a;
    int b;
    int pos;
    int valid;
    int dir;
    int br;
    int pulses;
    int errs;
    int per;
  } vec_t;
  vec_t tv [19];
  int n_chk = 0;
  int n_pass = 0;
  int np = 0;
  int ne = 0;
  always @(negedge clk) begin
    if (bus.step_pulse) np++;
    if (bus.step_err) ne++;
  end
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  function automatic logic [6:0] lit(input int s);
    logic [6:0] m;
    m = 7'h7f;
    m[s] = 1'b0;
    return m;
  endfunction
  // mode 0: segment a lit; 1: a and b alternate each cycle; 2: all lit b cycles of every 16
  task automatic drive(input int mode, input int a, input int b, input int n);
    for (int c = 0; c < n; c++) begin
      bus.seg_in = mode == 0 ? lit(a) : mode == 1 ? (((c % 2) != 0) ? lit(b) : lit(a)) :
                   (((c % 16) < b) ? 7'h00 : 7'h7f);
      @(posedge clk);
      #1;
    end
  endtask
  // leaves the bench 13 cycles after release so new inputs land exactly on a window start
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    repeat (12) @(posedge clk);
    #1;
  endtask
  initial begin
    tv[0]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tv[1]  = '{0, 1, 0, 1, 1, 1, 1, 1, 0, -1};
    tv[2]  = '{0, 6, 0, 2, 1, 1, 6, 1, 0, P32};
    tv[3]  = '{0, 4, 0, 3, 1, 1, 4, 1, 0, P32};
    tv[4]  = '{0, 3, 0, 4, 1, 1, 3, 1, 0, P32};
    tv[5]  = '{0, 2, 0, 5, 1, 1, 2, 1, 0, P32};
    tv[6]  = '{0, 6, 0, 6, 1, 1, 6, 1, 0, P32};
    tv[7]  = '{0, 5, 0, 7, 1, 1, 5, 1, 0, P32};
    tv[8]  = '{0, 0, 0, 0, 1, 1, 0, 1, 0, P32};
    tv[9]  = '{0, 5, 0, 7, 1, 0, 5, 1, 0, P32};
    tv[10] = '{0, 6, 0, 6, 1, 0, 6, 1, 0, P32};
    tv[11] = '{0, 5, 0, 7, 1, 1, 5, 1, 0, P32};
    tv[12] = '{0, 0, 0, 0, 1, 1, 0, 1, 0, P32};
    tv[13] = '{0, 3, 0, 4, 1, 1, 3, 0, 1, P32};
    tv[14] = '{1, 1, 4, 1, 1, 1, 1, 0, 1, P32};
    tv[15] = '{2, 0, 3, 1, 0, 1, 7, 0, 0, P32};
    tv[16] = '{2, 0, 4, 0, 1, 1, 0, 0, 0, P32};
    tv[17] = '{0, 6, 0, 0, 0, 1, 6, 0, 1, P32};
    tv[18] = '{0, 4, 0, 3, 1, 1, 4, 0, 0, P32};
    bus.seg_in = 7'h7f;
    #2;
    do_reset();
    drive(0, 0, 0, 32);
    chk("acq_brightest", int'(bus.brightest), 0);
    chk("acq_valid", int'(bus.pos_valid), 1);
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_pos", int'(bus.pos), 0);
    chk("rst_valid", int'(bus.pos_valid), 0);
    chk("rst_dir", int'(bus.dir), 0);
    chk("rst_brightest", int'(bus.brightest), 7);
    chk("rst_pulse", int'(bus.step_pulse), 0);
    chk("rst_err", int'(bus.step_err), 0);
    chk("rst_period", int'(bus.step_period), 0);
    bus.seg_in = 7'h7f;
    do_reset();
    chk("post_rst_brightest", int'(bus.brightest), 7);
    chk("post_rst_valid", int'(bus.pos_valid), 0);
    for (int i = 0; i < 19; i++) begin
      int np0, ne0;
      np0 = np;
      ne0 = ne;
      drive(tv[i].mode, tv[i].a, tv[i].b, 32);
      chk($sformatf("v%0d_pos", i), int'(bus.pos), tv[i].pos);
      chk($sformatf("v%0d_valid", i), int'(bus.pos_valid), tv[i].valid);
      chk($sformatf("v%0d_dir", i), int'(bus.dir), tv[i].dir);
      chk($sformatf("v%0d_brightest", i), int'(bus.brightest), tv[i].br);
      chk($sformatf("v%0d_pulses", i), np - np0, tv[i].pulses);
      chk($sformatf("v%0d_errs", i), ne - ne0, tv[i].errs);
      if (tv[i].per >= 0) chk($sformatf("v%0d_period", i), int'(bus.step_period), tv[i].per);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
